// File: rtl/rfft_pkg.sv
// Shared definitions for the 256-point radix-2 FFT core, its loader and its unload stage.
//   WIDTH / ADDR_W   : default sample word width and bank address width
//   NUM_BANKS/FFT_N  : result bank count and transform length
//   unload_state_e   : unload FSM state encoding
//   bitrev()         : bit reversal of a bank address
package rfft_pkg;

  localparam int unsigned WIDTH     = 32;
  localparam int unsigned ADDR_W    = 6;
  localparam int unsigned NUM_BANKS = 4;
  localparam int unsigned FFT_N     = 256;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SEND  = 2'd2,
    ST_FIN   = 2'd3
  } unload_state_e;

  // Reverse the bit order of a bank address.
  function automatic logic [ADDR_W-1:0] bitrev(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] r;
    r = {<<{a}};
    return r;
  endfunction

endpackage

// File: rtl/rfft_unload_if.sv
// Result stream from the FFT unload stage (valid/ready).
//   m_valid / m_ready : handshake
//   m_data            : result word
//   m_index           : {line, bank} of the word
//   m_last            : marks the final word of the transform
interface rfft_unload_if #(
  parameter int unsigned WIDTH  = rfft_pkg::WIDTH,
  parameter int unsigned ADDR_W = rfft_pkg::ADDR_W
);

  logic              m_valid;
  logic              m_ready;
  logic [WIDTH-1:0]  m_data;
  logic [ADDR_W+1:0] m_index;
  logic              m_last;

  modport master (output m_valid, m_data, m_index, m_last, input m_ready);
  modport slave  (input m_valid, m_data, m_index, m_last, output m_ready);

endinterface

// File: rtl/rfft_unload.sv
// Drains the four FFT result banks after the core finishes and streams the words
// out line-major, bank 0..3 within a line. One fetch cycle per line.
//   Clk, Reset_n          : clock, synchronous active-low reset
//   start                 : begin unload (ignored unless idle)
//   rd_en, rd_addr        : shared read port to all four banks
//   rd_data0..rd_data3    : bank outputs, 1-cycle latency, held while rd_en=0
//   m                     : result stream (master side)
//   busy, unload_done     : status; unload_done pulses once after the last accept
module rfft_unload #(
  parameter int unsigned WIDTH  = rfft_pkg::WIDTH,
  parameter int unsigned ADDR_W = rfft_pkg::ADDR_W,
  parameter bit          BITREV = 1'b0
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              start,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [WIDTH-1:0]  rd_data0,
  input  logic [WIDTH-1:0]  rd_data1,
  input  logic [WIDTH-1:0]  rd_data2,
  input  logic [WIDTH-1:0]  rd_data3,
  rfft_unload_if.master     m,
  output logic              busy,
  output logic              unload_done
);

  localparam logic [ADDR_W-1:0] LINE_MAX = '1;
  localparam logic [1:0]        SEL_MAX  = 2'd3;

  rfft_pkg::unload_state_e state_q, state_d;
  logic [ADDR_W-1:0] line_q, line_d;
  logic [1:0]        sel_q, sel_d;
  logic [ADDR_W-1:0] fetch_addr_c;
  logic              accept_c;

  logic              rd_en_d, m_valid_d, m_last_d, busy_d, unload_done_d;
  logic [ADDR_W-1:0] rd_addr_d;
  logic [ADDR_W+1:0] m_index_d;

  assign accept_c = m.m_valid & m.m_ready;

  // Bit-reversed storage is read back in natural order by reversing the line address.
  assign fetch_addr_c = BITREV ? ADDR_W'(rfft_pkg::bitrev(rfft_pkg::ADDR_W'(line_d))) : line_d;

  // Next state, counters and next values of the registered outputs.
  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    sel_d   = sel_q;
    case (state_q)
      rfft_pkg::ST_IDLE: begin
        if (start) begin
          state_d = rfft_pkg::ST_FETCH;
          line_d  = '0;
          sel_d   = '0;
        end
      end
      rfft_pkg::ST_FETCH: begin
        state_d = rfft_pkg::ST_SEND;
        sel_d   = '0;
      end
      rfft_pkg::ST_SEND: begin
        if (accept_c) begin
          if (sel_q != SEL_MAX) begin
            sel_d = sel_q + 2'd1;
          end else if (line_q != LINE_MAX) begin
            line_d  = line_q + ADDR_W'(1);
            state_d = rfft_pkg::ST_FETCH;
          end else begin
            state_d = rfft_pkg::ST_FIN;
          end
        end
      end
      rfft_pkg::ST_FIN: state_d = rfft_pkg::ST_IDLE;
      default:          state_d = rfft_pkg::ST_IDLE;
    endcase

    rd_en_d       = (state_d == rfft_pkg::ST_FETCH);
    // Address only moves on a fetch so the bank outputs stay put while sending.
    rd_addr_d     = rd_en_d ? fetch_addr_c : rd_addr;
    m_valid_d     = (state_d == rfft_pkg::ST_SEND);
    m_index_d     = {line_d, sel_d};
    m_last_d      = m_valid_d && (line_d == LINE_MAX) && (sel_d == SEL_MAX);
    busy_d        = (state_d == rfft_pkg::ST_FETCH) || (state_d == rfft_pkg::ST_SEND);
    unload_done_d = (state_d == rfft_pkg::ST_FIN);
  end

  // State and output registers.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q     <= rfft_pkg::ST_IDLE;
      line_q      <= '0;
      sel_q       <= '0;
      rd_en       <= 1'b0;
      rd_addr     <= '0;
      m.m_valid   <= 1'b0;
      m.m_index   <= '0;
      m.m_last    <= 1'b0;
      busy        <= 1'b0;
      unload_done <= 1'b0;
    end else begin
      state_q     <= state_d;
      line_q      <= line_d;
      sel_q       <= sel_d;
      rd_en       <= rd_en_d;
      rd_addr     <= rd_addr_d;
      m.m_valid   <= m_valid_d;
      m.m_index   <= m_index_d;
      m.m_last    <= m_last_d;
      busy        <= busy_d;
      unload_done <= unload_done_d;
    end
  end

  // Bank output mux straight onto the stream; no line buffer.
  always_comb begin
    case (sel_q)
      2'd0:    m.m_data = rd_data0;
      2'd1:    m.m_data = rd_data1;
      2'd2:    m.m_data = rd_data2;
      default: m.m_data = rd_data3;
    endcase
  end

endmodule

// File: tb/tb_rfft_unload.sv
// Self-checking bench for rfft_unload: natural-order DUT (scoreboarded stream,
// random backpressure, ignored start pulses, mid-unload reset) and a BITREV DUT.
module tb_rfft_unload;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned ADDR_W  = 6;
  localparam int unsigned LINES   = 64;
  localparam int unsigned NWORDS  = 256;
  localparam int          TIMEOUT = 5000;

  typedef struct packed {
    logic [7:0]       idx;
    logic [WIDTH-1:0] data;
    logic             last;
  } exp_t;

  typedef struct {
    int pct;
    bit spam;
    int exp_words;
    int exp_done;
  } run_t;

  typedef struct {
    int         line;
    logic [5:0] exp_addr;
  } addr_vec_t;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  logic start_main = 1'b0;
  logic start_spam = 1'b0;
  logic start;
  logic start1 = 1'b0;
  int   cyc = 0;

  assign start = start_main | start_spam;
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [WIDTH-1:0] exp_data(input int i);
    logic [7:0] iv;
    iv = 8'(i);
    return {16'hC0DE, 8'h00, iv[1:0], iv[7:2]};
  endfunction

  function automatic logic [5:0] tb_bitrev(input logic [5:0] a);
    logic [5:0] r;
    for (int k = 0; k < 6; k++) r[k] = a[5-k];
    return r;
  endfunction

  // DUT0: natural order
  logic              rd_en0, busy0, done0;
  logic [ADDR_W-1:0] rd_addr0;
  logic [WIDTH-1:0]  q0 [4];
  logic [WIDTH-1:0]  mem0 [4][LINES];
  rfft_unload_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) s0 ();

  rfft_unload #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .BITREV(1'b0)) dut0 (
    .Clk(Clk), .Reset_n(Reset_n), .start(start),
    .rd_en(rd_en0), .rd_addr(rd_addr0),
    .rd_data0(q0[0]), .rd_data1(q0[1]), .rd_data2(q0[2]), .rd_data3(q0[3]),
    .m(s0), .busy(busy0), .unload_done(done0)
  );

  always @(posedge Clk) if (rd_en0) for (int b = 0; b < 4; b++) q0[b] <= mem0[b][rd_addr0];

  // DUT1: bit-reversed storage
  logic              rd_en1, busy1, done1;
  logic [ADDR_W-1:0] rd_addr1;
  logic [WIDTH-1:0]  q1 [4];
  logic [WIDTH-1:0]  mem1 [4][LINES];
  rfft_unload_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) s1 ();

  rfft_unload #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .BITREV(1'b1)) dut1 (
    .Clk(Clk), .Reset_n(Reset_n), .start(start1),
    .rd_en(rd_en1), .rd_addr(rd_addr1),
    .rd_data0(q1[0]), .rd_data1(q1[1]), .rd_data2(q1[2]), .rd_data3(q1[3]),
    .m(s1), .busy(busy1), .unload_done(done1)
  );

  always @(posedge Clk) if (rd_en1) for (int b = 0; b < 4; b++) q1[b] <= mem1[b][rd_addr1];

  // DUT0 monitor / ready driver state
  exp_t             sb [$];
  int               rdy_pct = 100;
  bit               spam_en = 1'b0;
  int               acc_cnt, done_cnt, last_cnt;
  int               first_valid_cyc, first_rden_cyc, last_acc_cyc, done_cyc;
  bit               prev_stall = 1'b0;
  logic [7:0]       prev_idx;
  logic [WIDTH-1:0] prev_data;

  always @(negedge Clk) begin
    exp_t e;
    if (rdy_pct >= 100) s0.m_ready = 1'b1;
    else                s0.m_ready = (int'($urandom_range(99)) < rdy_pct);
    start_spam = spam_en && Reset_n &&
                 (rd_en0 || (s0.m_valid && s0.m_index[3:0] == 4'd5) || done0);
    if (Reset_n) begin
      if (prev_stall) begin
        chk("stall_valid", 64'(s0.m_valid), 64'd1);
        chk("stall_index", 64'(s0.m_index), 64'(prev_idx));
        chk("stall_data",  64'(s0.m_data),  64'(prev_data));
      end
      if (rd_en0 && first_rden_cyc < 0) first_rden_cyc = cyc;
      if (s0.m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (s0.m_valid && s0.m_ready) begin
        acc_cnt++;
        last_acc_cyc = cyc;
        if (s0.m_last) last_cnt++;
        chk("busy_in_send", 64'(busy0), 64'd1);
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL extra_word: got index %0h with empty scoreboard", s0.m_index);
        end else begin
          e = sb.pop_front();
          chk("index", 64'(s0.m_index), 64'(e.idx));
          chk("data",  64'(s0.m_data),  64'(e.data));
          chk("last",  64'(s0.m_last),  64'(e.last));
        end
      end
      if (done0) begin
        done_cnt++;
        done_cyc = cyc;
        chk("busy_in_fin", 64'(busy0), 64'd0);
      end
      prev_stall = s0.m_valid && !s0.m_ready;
      prev_idx   = s0.m_index;
      prev_data  = s0.m_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // DUT1 monitor
  logic [5:0] addr_q [$];
  int         acc1 = 0;
  int         done1_cnt = 0;

  always @(negedge Clk) begin
    s1.m_ready = 1'b1;
    if (Reset_n) begin
      if (rd_en1) addr_q.push_back(rd_addr1);
      if (s1.m_valid && s1.m_ready) begin
        chk("t5_index", 64'(s1.m_index), 64'(acc1));
        chk("t5_data",  64'(s1.m_data),  64'(exp_data(acc1)));
        acc1++;
      end
      if (done1) done1_cnt++;
    end
  end

  task automatic arm_scoreboard();
    exp_t e;
    sb.delete();
    for (int i = 0; i < int'(NWORDS); i++) begin
      e.idx  = 8'(i);
      e.data = exp_data(i);
      e.last = (i == int'(NWORDS) - 1);
      sb.push_back(e);
    end
    acc_cnt = 0; done_cnt = 0; last_cnt = 0;
    first_valid_cyc = -1; first_rden_cyc = -1; last_acc_cyc = -1; done_cyc = -1;
  endtask

  task automatic pulse_start(output int start_cyc);
    @(negedge Clk);
    start_main = 1'b1;
    start_cyc  = cyc;
    @(negedge Clk);
    start_main = 1'b0;
  endtask

  task automatic run_unload(input run_t r);
    int sc;
    rdy_pct = r.pct;
    arm_scoreboard();
    pulse_start(sc);
    spam_en = r.spam;
    for (int t = 0; t < TIMEOUT && done_cnt == 0; t++) @(posedge Clk);
    repeat (12) @(posedge Clk);
    spam_en = 1'b0;
    #1;
    chk("words",     64'(acc_cnt),   64'(r.exp_words));
    chk("done_cnt",  64'(done_cnt),  64'(r.exp_done));
    chk("last_cnt",  64'(last_cnt),  64'd1);
    chk("sb_empty",  64'(sb.size()), 64'd0);
    chk("idle_busy", 64'(busy0),     64'd0);
    chk("idle_valid", 64'(s0.m_valid), 64'd0);
    if (r.pct >= 100) begin
      chk("lat_rden",  64'(first_rden_cyc),  64'(sc + 1));
      chk("lat_valid", 64'(first_valid_cyc), 64'(sc + 2));
      chk("lat_last",  64'(last_acc_cyc),    64'(sc + 320));
      chk("lat_done",  64'(done_cyc),        64'(sc + 321));
    end
  endtask

  run_t      runs [4];
  addr_vec_t avec [8];

  initial begin
    int sc;
    runs[0] = '{pct: 100, spam: 1'b0, exp_words: 256, exp_done: 1};
    runs[1] = '{pct: 30,  spam: 1'b0, exp_words: 256, exp_done: 1};
    runs[2] = '{pct: 100, spam: 1'b1, exp_words: 256, exp_done: 1};
    runs[3] = '{pct: 30,  spam: 1'b1, exp_words: 256, exp_done: 1};
    avec[0] = '{line: 0, exp_addr: 6'd0};
    avec[1] = '{line: 1, exp_addr: 6'd32};
    avec[2] = '{line: 2, exp_addr: 6'd16};
    avec[3] = '{line: 3, exp_addr: 6'd48};
    avec[4] = '{line: 4, exp_addr: 6'd8};
    avec[5] = '{line: 5, exp_addr: 6'd40};
    avec[6] = '{line: 6, exp_addr: 6'd24};
    avec[7] = '{line: 7, exp_addr: 6'd56};

    for (int b = 0; b < 4; b++)
      for (int a = 0; a < int'(LINES); a++) begin
        mem0[b][a] = {16'hC0DE, 8'h00, 2'(b), 6'(a)};
        mem1[b][a] = {16'hC0DE, 8'h00, 2'(b), tb_bitrev(6'(a))};
      end

    // Reset state
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_rd_en",   64'(rd_en0),     64'd0);
    chk("rst_rd_addr", 64'(rd_addr0),   64'd0);
    chk("rst_valid",   64'(s0.m_valid), 64'd0);
    chk("rst_last",    64'(s0.m_last),  64'd0);
    chk("rst_busy",    64'(busy0),      64'd0);
    chk("rst_done",    64'(done0),      64'd0);
    Reset_n = 1'b1;
    repeat (2) @(posedge Clk);

    // Full unloads: back-to-back, backpressure, ignored start pulses
    for (int i = 0; i < 4; i++) run_unload(runs[i]);

    // Reset right after index 100 is accepted, then restart from index 0
    rdy_pct = 100;
    arm_scoreboard();
    pulse_start(sc);
    for (int t = 0; t < TIMEOUT; t++) begin
      @(posedge Clk);
      #1;
      if (acc_cnt == 101) break;
    end
    chk("t4_acc_before_rst", 64'(acc_cnt), 64'd101);
    Reset_n = 1'b0;
    @(posedge Clk);
    #1;
    chk("t4_valid", 64'(s0.m_valid), 64'd0);
    chk("t4_busy",  64'(busy0),      64'd0);
    chk("t4_rd_en", 64'(rd_en0),     64'd0);
    chk("t4_done",  64'(done0),      64'd0);
    Reset_n = 1'b1;
    repeat (2) @(posedge Clk);
    run_unload(runs[0]);

    // Bit-reversed storage, natural output order
    addr_q.delete();
    acc1 = 0;
    done1_cnt = 0;
    @(negedge Clk);
    start1 = 1'b1;
    @(negedge Clk);
    start1 = 1'b0;
    for (int t = 0; t < TIMEOUT && done1_cnt == 0; t++) @(posedge Clk);
    repeat (4) @(posedge Clk);
    chk("t5_words",   64'(acc1),          64'(NWORDS));
    chk("t5_done",    64'(done1_cnt),     64'd1);
    chk("t5_fetches", 64'(addr_q.size()), 64'(LINES));
    for (int k = 0; k < 8; k++)
      if (k < addr_q.size()) chk($sformatf("t5_addr_line%0d", avec[k].line), 64'(addr_q[k]), 64'(avec[k].exp_addr));
      else chk($sformatf("t5_addr_line%0d_missing", avec[k].line), 64'(addr_q.size()), 64'(k + 1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
